// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sharing controller.
//
// Contents:
//   ALU_W          operand/result width of the ALU datapath (16)
//   ALU_* codes    legal 4-bit op codes understood by the ALU
//   share_state_t  controller state encoding {IDLE, EXEC, RESP}
//   is_legal_op    returns 1 when an op code is one of the legal codes
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } share_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ALU.sv
// Single-cycle combinational 16-bit ALU.
//
// Ports:
//   i_op      4-bit op code (see alu_pkg)
//   i_a, i_b  operands
//   o_result  result, modulo 2^16; codes outside the legal set give 0
//   o_zero    1 when o_result is zero
module ALU
    import alu_pkg::*;
(
    input  logic [3:0]       i_op,
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    output logic [ALU_W-1:0] o_result,
    output logic             o_zero
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? ALU_W'(1) : '0;
            ALU_NOR: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/rr_grant2.sv
// Two-way round-robin grant.
//
// Ports:
//   i_valid       request valids, bit k = requester k
//   i_last_grant  requester that won the previous accepted request
//   o_grant       winning requester index (meaningful only when o_any)
//   o_any         at least one requester is valid
module rr_grant2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_any
);

    assign o_any = |i_valid;

    // On a tie the requester that did not win last time gets the slot;
    // otherwise the single valid requester wins (bit 1 set means it is 1).
    assign o_grant = (&i_valid) ? ~i_last_grant : i_valid[1];

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 16-bit ALU between two requesters (issue stage = 0,
// address-compute stage = 1). One operation in flight at a time:
// IDLE accepts, EXEC evaluates the registered op, RESP holds the result.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req_ready_k may depend on req_valid_*; requesters hold op/operands
// stable while valid and not ready. rsp_* are stable while
// rsp_valid && !rsp_ready.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid_k / req_ready_k     request handshake, k = 0,1
//   req_op_k, req_a_k, req_b_k    op code and operands
//   rsp_valid / rsp_ready         response handshake
//   rsp_id                        requester that issued the operation
//   rsp_result, rsp_zero          captured ALU result and zero flag
//   rsp_err                       illegal op (only with ALU_SHARE_ERR_EN)
//
// Build option: define ALU_SHARE_ERR_EN to flag illegal op codes; the
// response then carries rsp_err=1, result 0 and zero 1 for such ops.
module alu_share_ctrl
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid_0,
    output logic          req_ready_0,
    input  logic [3:0]    req_op_0,
    input  logic [15:0]   req_a_0,
    input  logic [15:0]   req_b_0,
    input  logic          req_valid_1,
    output logic          req_ready_1,
    input  logic [3:0]    req_op_1,
    input  logic [15:0]   req_a_1,
    input  logic [15:0]   req_b_1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [15:0]   rsp_result,
    output logic          rsp_zero
`ifdef ALU_SHARE_ERR_EN
    ,
    output logic          rsp_err
`endif
);

    localparam int W = ALU_W;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]   r_state;
    logic         r_last_grant;
    logic [3:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_id;
    logic [W-1:0] r_result;
    logic         r_zero;
`ifdef ALU_SHARE_ERR_EN
    logic         r_err;
`endif

    logic         w_grant;
    logic         w_any;
    logic         w_offer;
    logic         w_accept;
    logic [3:0]   w_op;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_alu_result;
    logic         w_alu_zero;

    rr_grant2 u_grant (
        .i_valid      ({req_valid_1, req_valid_0}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any        (w_any)
    );

    // Ready is offered only to the arbitration winner, never while reset
    // is asserted, so both readys can never be high together.
    assign w_offer     = rst_n && (r_state == S_IDLE) && w_any;
    assign req_ready_0 = w_offer && !w_grant;
    assign req_ready_1 = w_offer &&  w_grant;
    assign w_accept    = (req_ready_0 && req_valid_0) || (req_ready_1 && req_valid_1);

    assign w_op = w_grant ? req_op_1 : req_op_0;
    assign w_a  = w_grant ? req_a_1  : req_a_0;
    assign w_b  = w_grant ? req_b_1  : req_b_0;

    ALU u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
`ifdef ALU_SHARE_ERR_EN
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op         <= w_op;
                        r_a          <= w_a;
                        r_b          <= w_b;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
`ifdef ALU_SHARE_ERR_EN
                    if (!is_legal_op(r_op)) begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_err    <= 1'b1;
                    end else begin
                        r_result <= w_alu_result;
                        r_zero   <= w_alu_zero;
                        r_err    <= 1'b0;
                    end
`else
                    r_result <= w_alu_result;
                    r_zero   <= w_alu_zero;
`endif
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    // rsp_valid is high throughout RESP.
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
`ifdef ALU_SHARE_ERR_EN
    assign rsp_err    = r_err;
`endif

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbitrating controller that shares the single 16-bit `ALU` datapath between two requesters (issue stage and address-compute stage). It accepts one operation at a time over valid/ready handshakes using round-robin arbitration. It registers operands into the ALU, captures the result and zero flag, and returns them on one shared response channel tagged with the requester ID.

## Interface
Parameters:
- `W`, 16: operand and result width; fixed to the `ALU` width, not overridable.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid_0` / `req_valid_1` in 1: request valid.
- `req_ready_0` / `req_ready_1` out 1: request accepted this cycle.
- `req_op_0` / `req_op_1` in 4: ALU op code.
- `req_a_0`, `req_b_0` / `req_a_1`, `req_b_1` in 16: operands.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_result` out 16: ALU result.
- `rsp_zero` out 1: ALU zero flag.
- `rsp_err` out 1: illegal op. Present only with `ALU_SHARE_ERR_EN`.

## Operation
- FSM has three states:
  - IDLE: accepts a request.
  - EXEC: ALU evaluates the registered op and operands; result and zero are captured at the end of the cycle.
  - RESP: holds the response until `rsp_ready`.
- Transitions:
  - IDLE→EXEC on an accepted request.
  - EXEC→RESP unconditionally.
  - RESP→IDLE when `rsp_valid && rsp_ready`.
- Arbitration:
  - `req_ready_k = (state==IDLE) && grant==k && rsp_n`.
  - `grant` is combinational from the valids and `last_grant`.
  - A single valid requester always wins.
  - When both are valid, the winner is the requester that is not `last_grant`.
  - `last_grant` updates only on acceptance.
- Handshake rules:
  - Ready may depend on valid. Requesters must hold op and operands stable while valid and not ready.
  - Outputs `rsp_*` are stable while `rsp_valid && !rsp_ready`.
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- Op handling is forwarded unchanged to `ALU`. No width growth; carry out is discarded (modulo 2^16).

## Timing
- Reset (`rst_n` low at a rising edge):
  - state=IDLE, `last_grant`=1 (requester 0 wins first tie).
  - `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_id`=0, `rsp_err`=0.
  - `req_ready_*` forced 0 while `rst_n` is low.
- Latency: request accepted in cycle N → `rsp_valid` high from cycle N+2.
- Throughput: at most one operation per 3 cycles with `rsp_ready` held high.
- The next request can be accepted in the cycle after the response handshake.
- Boundary cases:
  - Both requesters valid in IDLE: exactly one `req_ready` is asserted, never both.
  - Reset in EXEC or RESP: the in-flight operation is dropped and no response is produced. IDLE applies in the first cycle with `rst_n` high.
  - `rsp_ready` held low indefinitely: the FSM stays in RESP and both `req_ready` stay 0.
  - `req_valid` deasserted before acceptance: no state change.

## Configuration
- `ALU_SHARE_ERR_EN` defined:
  - An op outside the legal set is accepted and flows through EXEC normally.
  - The response carries `rsp_err`=1, `rsp_result`=0 and `rsp_zero`=1; the ALU output is ignored.
  - `rsp_err`=0 for legal ops.
- `ALU_SHARE_ERR_EN` undefined: the `rsp_err` port is absent and every op code is passed to `ALU` as-is.

## Structure
- Shared package `alu_pkg` holds:
  - Op-code constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`.
  - State enum `share_state_t` {IDLE, EXEC, RESP}.
  - Width constant `ALU_W`=16.
- One sub-module: `rr_grant2`, a two-way round-robin grant (inputs: valids, `last_grant`; output: grant, any).
- `ALU` is instantiated unmodified.

## Test plan
- ADD: requester 0 sends op 0010, a=0x0003, b=0x0004 → `rsp_valid` at N+2, result 0x0007, zero 0, id 0.
- SUB and SLT from requester 1:
  - SUB 0110, a=b=0x0005 → result 0x0000, zero 1, id 1.
  - SLT 0111, a=0xFFFF, b=0x0001 → result 0x0001.
- Round-robin: both requesters valid continuously for three operations → grant order 0,1,0. Each response `rsp_id` matches the grant.
- Backpressure: `rsp_ready` low 3 cycles after `rsp_valid` → `rsp_result`, `rsp_id` and `rsp_zero` stable, `req_ready_*`=0. The handshake completes in the cycle `rsp_ready` rises.
- Reset in EXEC: `rst_n` low one cycle → `rsp_valid` never asserts for that op. A request issued right after release completes at acceptance+2.
- With `ALU_SHARE_ERR_EN`: op 0101 → `rsp_err` 1, result 0x0000, zero 1. Without the macro, the same op returns the raw `ALU` output.
